// File: rtl/scan_bus_pkg.sv
// Shared types and defaults for the scan-chain to bus sequencer.
package scan_bus_pkg;

  localparam int unsigned ADDR_W_DEF       = 16;
  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned CTRL_SEL_BIT_DEF = 11;
  localparam logic [DATA_W_DEF-1:0] ERR_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } scan_bus_state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } scan_bus_req_t;

endpackage

// File: rtl/scan_toggle_sync.sv
// Two-flop synchronizer plus history flop; flags either edge of an async strobe.
module scan_toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic toggle_c
);

  logic [2:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  assign toggle_c = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/scan_bus_ctrl.sv
// Runs one valid/ready transaction per scan_id toggle on the SRAM or control port
// and hands rdata/ready/err back to the scan bank.
module scan_bus_ctrl
  import scan_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CTRL_SEL_BIT = CTRL_SEL_BIT_DEF,
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_id,
  input  logic              cmd_wen,
  input  logic              cmd_ren,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [DATA_W-1:0] cmd_rdata,
  output logic              cmd_ready,
  output logic              cmd_err,
  output logic              cmd_overrun,
  output logic              sram_req_valid,
  input  logic              sram_req_ready,
  output logic              sram_req_we,
  output logic [ADDR_W-1:0] sram_req_addr,
  output logic [DATA_W-1:0] sram_req_wdata,
  input  logic              sram_rsp_valid,
  input  logic [DATA_W-1:0] sram_rsp_rdata,
  output logic              ctrl_req_valid,
  input  logic              ctrl_req_ready,
  output logic              ctrl_req_we,
  output logic [ADDR_W-1:0] ctrl_req_addr,
  output logic [DATA_W-1:0] ctrl_req_wdata,
  input  logic              ctrl_rsp_valid,
  input  logic [DATA_W-1:0] ctrl_rsp_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  scan_bus_state_e   state_q;
  logic              toggle_c;
  logic              op_we_q;
  logic              op_sel_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic [DATA_W-1:0] op_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;
  logic              overrun_q;
  logic              sram_valid_q;
  logic              ctrl_valid_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              req_ready_sel;
  logic              rsp_valid_sel;
  logic [DATA_W-1:0] rsp_rdata_sel;

  scan_toggle_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_i  (scan_id),
    .toggle_c (toggle_c)
  );

  // Only the port chosen at command latch time is ever listened to.
  assign req_ready_sel = op_sel_q ? ctrl_req_ready : sram_req_ready;
  assign rsp_valid_sel = op_sel_q ? ctrl_rsp_valid : sram_rsp_valid;
  assign rsp_rdata_sel = op_sel_q ? ctrl_rsp_rdata : sram_rsp_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_we_q      <= 1'b0;
      op_sel_q     <= 1'b0;
      op_addr_q    <= '0;
      op_wdata_q   <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
      sram_valid_q <= 1'b0;
      ctrl_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (toggle_c) begin
            op_we_q    <= cmd_wen;
            op_sel_q   <= cmd_addr[CTRL_SEL_BIT];
            op_addr_q  <= cmd_addr;
            op_wdata_q <= cmd_wdata;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
            if (cmd_wen == cmd_ren) begin
              state_q <= ST_DONE;
              if (cmd_wen) begin
                err_q   <= 1'b1;
                rdata_q <= ERR_DATA;
              end
            end else begin
              state_q      <= ST_ISSUE;
              sram_valid_q <= ~cmd_addr[CTRL_SEL_BIT];
              ctrl_valid_q <= cmd_addr[CTRL_SEL_BIT];
            end
          end
        end
        ST_ISSUE: begin
          if (req_ready_sel) begin
            sram_valid_q <= 1'b0;
            ctrl_valid_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= op_we_q ? ST_DONE : ST_WAIT_RSP;
          end else if (cnt_q == CNT_LAST) begin
            sram_valid_q <= 1'b0;
            ctrl_valid_q <= 1'b0;
            err_q        <= 1'b1;
            rdata_q      <= ERR_DATA;
            state_q      <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_valid_sel) begin
            rdata_q <= rsp_rdata_sel;
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= ERR_DATA;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // A strobe that lands while busy is dropped but remembered.
      if (toggle_c && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign cmd_rdata      = rdata_q;
  assign cmd_ready      = ready_q;
  assign cmd_err        = err_q;
  assign cmd_overrun    = overrun_q;
  assign sram_req_valid = sram_valid_q;
  assign sram_req_we    = op_we_q;
  assign sram_req_addr  = op_addr_q;
  assign sram_req_wdata = op_wdata_q;
  assign ctrl_req_valid = ctrl_valid_q;
  assign ctrl_req_we    = op_we_q;
  assign ctrl_req_addr  = op_addr_q;
  assign ctrl_req_wdata = op_wdata_q;

endmodule

// File: tb/tb_scan_bus_ctrl.sv
// Directed plus randomized checks of scan_bus_ctrl against a command-level reference model.
module tb_scan_bus_ctrl;

  localparam int unsigned SEL = 11;
  localparam int unsigned TO  = 64;
  localparam logic [15:0] ERRD = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_id;
  logic        cmd_wen, cmd_ren;
  logic [15:0] cmd_addr, cmd_wdata, cmd_rdata;
  logic        cmd_ready, cmd_err, cmd_overrun;
  logic        sram_req_valid, sram_req_ready, sram_req_we;
  logic [15:0] sram_req_addr, sram_req_wdata;
  logic        sram_rsp_valid;
  logic [15:0] sram_rsp_rdata;
  logic        ctrl_req_valid, ctrl_req_ready, ctrl_req_we;
  logic [15:0] ctrl_req_addr, ctrl_req_wdata;
  logic        ctrl_rsp_valid;
  logic [15:0] ctrl_rsp_rdata;

  int checks = 0;
  int errors = 0;
  int sram_hs = 0, ctrl_hs = 0, sram_vc = 0, ctrl_vc = 0;

  // Reference model state: what the scan bank should see after each command.
  logic [15:0] m_rdata;
  logic        m_err;

  always #5 clk = ~clk;

  scan_bus_ctrl #(
    .ADDR_W(16), .DATA_W(16), .CTRL_SEL_BIT(SEL), .TIMEOUT(TO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_id(scan_id),
    .cmd_wen(cmd_wen), .cmd_ren(cmd_ren), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_rdata(cmd_rdata), .cmd_ready(cmd_ready), .cmd_err(cmd_err), .cmd_overrun(cmd_overrun),
    .sram_req_valid(sram_req_valid), .sram_req_ready(sram_req_ready), .sram_req_we(sram_req_we),
    .sram_req_addr(sram_req_addr), .sram_req_wdata(sram_req_wdata),
    .sram_rsp_valid(sram_rsp_valid), .sram_rsp_rdata(sram_rsp_rdata),
    .ctrl_req_valid(ctrl_req_valid), .ctrl_req_ready(ctrl_req_ready), .ctrl_req_we(ctrl_req_we),
    .ctrl_req_addr(ctrl_req_addr), .ctrl_req_wdata(ctrl_req_wdata),
    .ctrl_rsp_valid(ctrl_rsp_valid), .ctrl_rsp_rdata(ctrl_rsp_rdata)
  );

  always @(posedge clk) begin
    if (sram_req_valid) sram_vc++;
    if (ctrl_req_valid) ctrl_vc++;
    if (sram_req_valid && sram_req_ready) sram_hs++;
    if (ctrl_req_valid && ctrl_req_ready) ctrl_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_cmd(input logic wen, input logic ren, input logic [15:0] addr,
                           input logic [15:0] wdata);
    cmd_wen   = wen;
    cmd_ren   = ren;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    scan_id   = ~scan_id;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(sram_req_valid || ctrl_req_valid) && lat < 10);
  endtask

  // stall: -1 = req_ready already high, else cycles of ready low after valid.
  // rsp_dly: -1 = never respond, 0 = rsp_valid held high from the start, N = N cycles after handshake.
  task automatic run_op(input logic wen, input logic ren, input logic [15:0] addr,
                        input logic [15:0] wdata, input int stall, input int rsp_dly,
                        input logic [15:0] rsp_data, input bit ovr);
    logic sel;
    bit   active, stable;
    int   lat, s_hs0, c_hs0, s_vc0, c_vc0;
    sel    = addr[SEL];
    active = (wen != ren);
    s_hs0 = sram_hs; c_hs0 = ctrl_hs; s_vc0 = sram_vc; c_vc0 = ctrl_vc;

    if (wen && ren) begin
      m_err = 1'b1; m_rdata = ERRD;
    end else if (!active || wen) begin
      m_err = 1'b0;
    end else if (rsp_dly < 0) begin
      m_err = 1'b1; m_rdata = ERRD;
    end else begin
      m_err = 1'b0; m_rdata = rsp_data;
    end

    if (active && stall < 0) begin
      if (sel) ctrl_req_ready = 1'b1; else sram_req_ready = 1'b1;
    end
    if (active && ren && rsp_dly == 0) begin
      if (sel) begin ctrl_rsp_valid = 1'b1; ctrl_rsp_rdata = rsp_data; end
      else begin sram_rsp_valid = 1'b1; sram_rsp_rdata = rsp_data; end
    end
    start_cmd(wen, ren, addr, wdata);

    if (active) begin
      wait_valid(lat);
      chk("valid_latency", 32'(lat >= 3 && lat <= 4), 32'd1);
      chk("sram_valid_sel", sram_req_valid, !sel);
      chk("ctrl_valid_sel", ctrl_req_valid, sel);
      chk("req_we", sel ? ctrl_req_we : sram_req_we, wen);
      chk("req_addr", sel ? ctrl_req_addr : sram_req_addr, addr);
      chk("req_wdata", sel ? ctrl_req_wdata : sram_req_wdata, wdata);
      chk("ready_cleared", cmd_ready, 1'b0);
      cmd_wen = 1'($urandom); cmd_ren = 1'($urandom);
      cmd_addr = 16'($urandom); cmd_wdata = 16'($urandom);
      if (ovr) scan_id = ~scan_id;
      if (stall >= 0) begin
        stable = 1'b1;
        repeat (stall) begin
          tick();
          if (sel) begin
            if (!(ctrl_req_valid && ctrl_req_we == wen && ctrl_req_addr == addr &&
                  ctrl_req_wdata == wdata)) stable = 1'b0;
          end else begin
            if (!(sram_req_valid && sram_req_we == wen && sram_req_addr == addr &&
                  sram_req_wdata == wdata)) stable = 1'b0;
          end
        end
        chk("req_stable", 32'(stable), 32'd1);
        if (sel) ctrl_req_ready = 1'b1; else sram_req_ready = 1'b1;
      end
      tick();
      sram_req_ready = 1'b0;
      ctrl_req_ready = 1'b0;
      chk("valid_drop", sram_req_valid | ctrl_req_valid, 1'b0);

      if (wen) begin
        if (stall < 0) begin
          chk("wr_ready_early", cmd_ready, 1'b0);
          tick();
          chk("wr_ready_lat2", cmd_ready, 1'b1);
        end
      end else if (rsp_dly == 0) begin
        tick();
        chk("rd_ready_early", cmd_ready, 1'b0);
        tick();
        chk("rd_ready_lat", cmd_ready, 1'b1);
        sram_rsp_valid = 1'b0;
        ctrl_rsp_valid = 1'b0;
      end else if (rsp_dly > 0) begin
        if (sel) begin sram_rsp_valid = 1'b1; sram_rsp_rdata = ~rsp_data; end
        else begin ctrl_rsp_valid = 1'b1; ctrl_rsp_rdata = ~rsp_data; end
        repeat (rsp_dly - 1) tick();
        if (sel) begin ctrl_rsp_valid = 1'b1; ctrl_rsp_rdata = rsp_data; end
        else begin sram_rsp_valid = 1'b1; sram_rsp_rdata = rsp_data; end
        tick();
        sram_rsp_valid = 1'b0;
        ctrl_rsp_valid = 1'b0;
      end else begin
        repeat (TO - 1) tick();
        chk("to_err_early", cmd_err, 1'b0);
        tick();
        chk("to_err", cmd_err, 1'b1);
        chk("to_rdata", cmd_rdata, ERRD);
      end
    end else begin
      repeat (3) tick();
      chk("ready_cleared", cmd_ready, 1'b0);
    end

    lat = 0;
    while (!cmd_ready && lat < 12) begin
      tick();
      lat++;
    end
    chk("cmd_ready", cmd_ready, 1'b1);
    chk("cmd_err", cmd_err, m_err);
    chk("cmd_rdata", cmd_rdata, m_rdata);
    chk("cmd_overrun", cmd_overrun, ovr);
    chk("sram_handshakes", 32'(sram_hs - s_hs0), 32'(active && !sel));
    chk("ctrl_handshakes", 32'(ctrl_hs - c_hs0), 32'(active && sel));
    if (!active) begin
      chk("no_valid_sram", 32'(sram_vc - s_vc0), 32'd0);
      chk("no_valid_ctrl", 32'(ctrl_vc - c_vc0), 32'd0);
    end else if (sel) begin
      chk("idle_sram_port", 32'(sram_vc - s_vc0), 32'd0);
    end else begin
      chk("idle_ctrl_port", 32'(ctrl_vc - c_vc0), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sram_valid"}, sram_req_valid, 1'b0);
    chk({tag, "_ctrl_valid"}, ctrl_req_valid, 1'b0);
    chk({tag, "_req_fields"}, {sram_req_we, sram_req_addr, sram_req_wdata, ctrl_req_we,
                               ctrl_req_addr, ctrl_req_wdata} == '0, 1'b1);
    chk({tag, "_rdata"}, cmd_rdata, 16'h0000);
    chk({tag, "_ready"}, cmd_ready, 1'b0);
    chk({tag, "_err"}, cmd_err, 1'b0);
    chk({tag, "_overrun"}, cmd_overrun, 1'b0);
  endtask

  initial begin
    int lat, r, stall, dly;
    logic [15:0] a;
    rst_n = 1'b0; scan_id = 1'b0;
    cmd_wen = 1'b0; cmd_ren = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    sram_req_ready = 1'b0; sram_rsp_valid = 1'b0; sram_rsp_rdata = '0;
    ctrl_req_ready = 1'b0; ctrl_rsp_valid = 1'b0; ctrl_rsp_rdata = '0;
    m_rdata = '0; m_err = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    run_op(1'b1, 1'b0, 16'h0001, 16'h4321, 5, 1, 16'h0000, 1'b0);
    run_op(1'b0, 1'b1, 16'h0800, 16'h0000, 2, 3, 16'h4567, 1'b0);
    run_op(1'b0, 1'b1, 16'h0011, 16'h0000, 1, -1, 16'h0000, 1'b0);

    sram_rsp_valid = 1'b1; sram_rsp_rdata = 16'h1234;
    repeat (2) tick();
    sram_rsp_valid = 1'b0;
    tick();
    chk("stray_rdata", cmd_rdata, ERRD);
    chk("stray_err", cmd_err, 1'b1);
    chk("stray_ready", cmd_ready, 1'b1);

    run_op(1'b1, 1'b1, 16'h0003, 16'h5555, 0, 1, 16'h0000, 1'b0);
    run_op(1'b0, 1'b0, 16'h0804, 16'h7777, 0, 1, 16'h0000, 1'b0);
    run_op(1'b1, 1'b0, 16'h0802, 16'h9999, 6, 1, 16'h0000, 1'b1);
    run_op(1'b1, 1'b0, 16'h0004, 16'hA5A5, -1, 1, 16'h0000, 1'b0);
    run_op(1'b0, 1'b1, 16'h0805, 16'h0000, -1, 0, 16'hBEEF, 1'b0);

    // Reset pulse while a read sits in WAIT_RSP.
    start_cmd(1'b0, 1'b1, 16'h0011, 16'h0000);
    wait_valid(lat);
    chk("rst_seq_valid", sram_req_valid, 1'b1);
    sram_req_ready = 1'b1;
    tick();
    sram_req_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0; scan_id = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    m_rdata = '0; m_err = 1'b0;
    tick();
    run_op(1'b0, 1'b1, 16'h0007, 16'h0000, 2, 2, 16'h3C3C, 1'b0);

    for (int i = 0; i < 12; i++) begin
      r     = int'($urandom_range(0, 9));
      stall = int'($urandom_range(0, 7)) - 1;
      dly   = int'($urandom_range(0, 6));
      a     = 16'($urandom);
      if (r == 0)      run_op(1'b1, 1'b1, a, 16'($urandom), stall, dly, 16'($urandom), 1'b0);
      else if (r == 1) run_op(1'b0, 1'b0, a, 16'($urandom), stall, dly, 16'($urandom), 1'b0);
      else if (r < 6)  run_op(1'b1, 1'b0, a, 16'($urandom), stall, dly, 16'($urandom), 1'b0);
      else             run_op(1'b0, 1'b1, a, 16'($urandom), stall, dly, 16'($urandom), 1'b0);
      repeat (int'($urandom_range(0, 4))) tick();
      chk("ready_hold", cmd_ready, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_bus_ctrl.md
# scan_bus_ctrl

On-chip sequencer between the scan-chain register bank and the SIMD engine's memory/control buses. It detects a toggle on the asynchronous `scan_id` strobe and samples the scan-loaded command fields (`wen`, `ren`, `addr`, `wdata`). It then performs exactly one valid/ready transaction on either the SRAM port or the control-register port. On completion it returns `rdata` and `ready` to the scan bank, where they are captured by the next chain load.

## Interface
Parameters:
- `ADDR_W`, 16, command address width
- `DATA_W`, 16, data width
- `CTRL_SEL_BIT`, 11, address bit selecting the control-register port (1) or the SRAM port (0)
- `TIMEOUT`, 64, cycles to wait for `*_req_ready` or `*_rsp_valid` before aborting
- `ERR_DATA`, 16'hDEAD, `rdata` value returned on error or timeout

Ports:
- `clk`, in, 1, sole clock
- `rst_n`, in, 1, reset: synchronous, active-low
- `scan_id`, in, 1, asynchronous operation strobe; each toggle (either edge) is one command
- `cmd_wen`, `cmd_ren`, in, 1 each, command type from the scan bank
- `cmd_addr`, in, ADDR_W, command address
- `cmd_wdata`, in, DATA_W, command write data
- `cmd_rdata`, out, DATA_W, read result to the scan bank
- `cmd_ready`, out, 1, command complete
- `cmd_err`, out, 1, last command errored or timed out
- `cmd_overrun`, out, 1, sticky: a toggle arrived while busy
- `sram_req_valid`, out, 1; `sram_req_ready`, in, 1; `sram_req_we`, out, 1; `sram_req_addr`, out, ADDR_W; `sram_req_wdata`, out, DATA_W
- `sram_rsp_valid`, in, 1; `sram_rsp_rdata`, in, DATA_W
- `ctrl_req_*` / `ctrl_rsp_*`: identical set for the control-register port

## Operation
- `scan_id` passes through a 2-flop synchronizer plus a third flop. `toggle = s2 ^ s3`.
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
- **IDLE**
  - On `toggle`: latch `cmd_*` into internal op registers, clear `cmd_ready`, `cmd_err` and `cmd_overrun`, load the timeout counter with 0.
  - `wen & ren`, or neither set: go directly to DONE. For `wen & ren`, `cmd_err=1` and `rdata=ERR_DATA`. For neither set, this is a no-op and `rdata` is unchanged.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Assert `valid` on the port selected by `addr[CTRL_SEL_BIT]`. `we`, `addr` and `wdata` are held stable while `valid` is high.
  - On `valid & req_ready`, deassert `valid`. A write goes to DONE; a read goes to WAIT_RSP.
- **WAIT_RSP**: on `rsp_valid` from the selected port, capture `rsp_rdata` into `cmd_rdata` and go to DONE.
- **DONE**: set `cmd_ready=1` for one transition, then go to IDLE. `cmd_ready` stays 1 until the next accepted toggle.
- **Timeout**
  - The counter increments each cycle in ISSUE and WAIT_RSP, and resets on entry to each state.
  - When it reaches `TIMEOUT-1` without a handshake: drop `valid`, `cmd_err=1`, `cmd_rdata=ERR_DATA`, go to DONE.
  - A late `rsp_valid` arriving in IDLE is ignored.
- **Overrun**: a toggle in any non-IDLE state is dropped and sets `cmd_overrun` (sticky until the next accepted toggle).
- Response data from the non-selected port is ignored at all times.

## Timing
- Reset values: all `*_req_valid=0`, `req_we/addr/wdata=0`, `cmd_rdata=0`, `cmd_ready=0`, `cmd_err=0`, `cmd_overrun=0`, FSM=IDLE.
- The synchronizer flops reset to 0. If `scan_id` is 1 at reset release, a toggle follows; this is intended, since the bench starts with `scan_id=0`.
- Latency from a `scan_id` edge to `valid` rising is 3–4 clk.
- A write with `req_ready` already high raises `cmd_ready` 2 cycles after `valid`.
- A read with zero-wait `rsp_valid` raises `cmd_ready` 3 cycles after `valid`.
- `rsp_valid` may be asserted in the same cycle as the request handshake. It is sampled only from WAIT_RSP onward, so a response must arrive at least 1 cycle after the handshake.
- Reset mid-operation aborts immediately: `valid` drops in the cycle following `rst_n=0`. No partial state is retained.
- `cmd_*` inputs are sampled only in the IDLE toggle cycle. Scan-side changes afterwards do not affect the op in flight.

## Structure
- Package `scan_bus_pkg`:
  - FSM state enum `scan_bus_state_e`
  - defaults for `ADDR_W` / `DATA_W` / `CTRL_SEL_BIT` / `ERR_DATA`
  - struct `scan_bus_req_t` {`we`, `addr`, `wdata`}
- One sub-module, `scan_toggle_sync` (3-flop synchronizer plus XOR edge detect). It is reusable for `scan_load_chip`.
- Port muxing and the FSM live in the top level.

## Test plan
- Write `addr=16'h0001`, `wdata=16'h4321`, SRAM with `req_ready` stalled 5 cycles → one SRAM handshake with `we=1`, fields stable during the stall, `cmd_ready=1`, `cmd_err=0`, no ctrl-port activity.
- Read `addr=16'h0800`, ctrl `rsp_rdata=16'h4567` returned 3 cycles after the handshake → handshake on the ctrl port only; `cmd_rdata=16'h4567`, `cmd_ready=1`.
- Read `addr=16'h0011` with SRAM `rsp_valid` never asserted → `cmd_rdata=16'hDEAD` and `cmd_err=1`, both after exactly `TIMEOUT` cycles in WAIT_RSP. A later stray `rsp_valid` leaves the outputs unchanged.
- Command with `wen=1`, `ren=1` → no `req_valid` on either port; `cmd_err=1`, `cmd_rdata=16'hDEAD`, `cmd_ready=1`.
- Second `scan_id` toggle while in ISSUE → exactly one transaction; `cmd_overrun=1`, cleared by the next accepted toggle.
- `rst_n=0` for one cycle during WAIT_RSP → all outputs at reset values next cycle; a following read of `16'h0007` completes normally.
